si53xx_cfg_sequencer: RTL and testbench

- Controller that owns the register-level transaction port of the si53xx SPI interface.
- Sequences Si53xx PLL bring-up: startup wait, ROM config stream with embedded delay markers, then a lock poll on a status register.
- After bring-up, arbitrates between re-configuration and a single host register-access port.
- Sits between the config ROM / host logic and the SPI engine. The engine does one 8-bit register read or write per request.

---
 rtl/si53xx_pkg.sv | 47 ++++
 rtl/si53xx_txn_issuer.sv | 62 ++++++
 rtl/si53xx_cfg_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_si53xx_cfg_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/si53xx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : si53xx_pkg
// Description : Shared constants for the Si53xx configuration sequencer:
//               FSM state encoding, ROM delay-marker byte, page register
//               address and default lock-status register/mask.
// Revision    : 1.0 - initial release
// ============================================================================
package si53xx_pkg;

    // State encoding (explicit 4-bit width)
    localparam logic [3:0] C_ST_STARTUP   = 4'd0;
    localparam logic [3:0] C_ST_FETCH     = 4'd1;
    localparam logic [3:0] C_ST_ROM_WAIT  = 4'd2;
    localparam logic [3:0] C_ST_ROM_WR    = 4'd3;
    localparam logic [3:0] C_ST_DELAY     = 4'd4;
    localparam logic [3:0] C_ST_POLL_PG   = 4'd5;
    localparam logic [3:0] C_ST_POLL_RD   = 4'd6;
    localparam logic [3:0] C_ST_POLL_WAIT = 4'd7;
    localparam logic [3:0] C_ST_IDLE      = 4'd8;
    localparam logic [3:0] C_ST_HOST      = 4'd9;
    localparam logic [3:0] C_ST_ERROR     = 4'd10;

    typedef enum logic [3:0] {
        ST_STARTUP   = C_ST_STARTUP,
        ST_FETCH     = C_ST_FETCH,
        ST_ROM_WAIT  = C_ST_ROM_WAIT,
        ST_ROM_WR    = C_ST_ROM_WR,
        ST_DELAY     = C_ST_DELAY,
        ST_POLL_PG   = C_ST_POLL_PG,
        ST_POLL_RD   = C_ST_POLL_RD,
        ST_POLL_WAIT = C_ST_POLL_WAIT,
        ST_IDLE      = C_ST_IDLE,
        ST_HOST      = C_ST_HOST,
        ST_ERROR     = C_ST_ERROR
    } state_t;

    // ROM entry whose address byte equals this is a wait, not a write
    localparam logic [7:0] C_DELAY_MARKER    = 8'hFF;
    // Page-select register and the page holding the status register
    localparam logic [7:0] C_PAGE_REG        = 8'h01;
    localparam logic [7:0] C_PAGE0           = 8'h00;
    localparam logic [7:0] C_STATUS_ADDR_DEF = 8'h0C;
    localparam logic [7:0] C_STATUS_MASK_DEF = 8'h0F;

endpackage
`default_nettype wire

// File: rtl/si53xx_txn_issuer.sv
`default_nettype none
// ============================================================================
// Module      : si53xx_txn_issuer
// Description : Holds one SPI register transaction. A start pulse while idle
//               captures rnw/addr/wdata and raises spi_req; the request and
//               its fields stay stable until spi_done, then req drops on the
//               following edge. A start in the done cycle is ignored, which
//               guarantees an idle cycle between requests.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start, rnw, addr, wdata - new transaction (used when idle)
//               spi_done          - engine completion pulse
//               spi_req/rnw/addr/wdata - registered request to the engine
//               txn_done          - spi_done qualified by an open request
// Revision    : 1.0 - initial release
// ============================================================================
module si53xx_txn_issuer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rnw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       spi_done,
    output logic       spi_req,
    output logic       spi_rnw,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_wdata,
    output logic       txn_done
);

    logic       r_req;
    logic       r_rnw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_rnw   <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
        end else if (r_req) begin
            if (spi_done) begin
                r_req <= 1'b0;
            end
        end else if (start) begin
            r_req   <= 1'b1;
            r_rnw   <= rnw;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    assign spi_req   = r_req;
    assign spi_rnw   = r_rnw;
    assign spi_addr  = r_addr;
    assign spi_wdata = r_wdata;
    // A stray done after an aborted request must not count
    assign txn_done  = r_req & spi_done;

endmodule
`default_nettype wire

// File: rtl/si53xx_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : si53xx_cfg_sequencer
// Description : Si53xx PLL bring-up controller. Waits STARTUP_CYCLES, streams
//               the config ROM as register writes (addr byte 8'hFF = delay
//               marker), selects page 0 and polls the status register until
//               the masked bits read zero. Afterwards serves a single host
//               register port, and re-runs bring-up on start_cfg.
// Ports       : clk, reset                 - clock, sync active-high reset
//               start_cfg                  - rerun bring-up (IDLE/ERROR only)
//               rom_addr, rom_data         - config ROM (1-cycle latency)
//               spi_req/rnw/addr/wdata     - request to SPI engine
//               spi_done, spi_rdata        - engine completion and read data
//               host_req/rnw/addr/wdata    - host access request (level)
//               host_ack, host_rdata       - host completion and read data
//               cfg_done, busy, error      - status
// Revision    : 1.0 - initial release
// ============================================================================
module si53xx_cfg_sequencer
    import si53xx_pkg::*;
#(
    parameter int          ROM_DEPTH      = 614,
    parameter logic [31:0] STARTUP_CYCLES = 32'd100,
    parameter logic [31:0] DELAY_CYCLES   = 32'd30000000,
    parameter logic [31:0] POLL_INTERVAL  = 32'd100000,
    parameter int          POLL_LIMIT     = 255,
    parameter logic [7:0]  STATUS_ADDR    = C_STATUS_ADDR_DEF,
    parameter logic [7:0]  STATUS_MASK    = C_STATUS_MASK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_cfg,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        spi_req,
    output logic        spi_rnw,
    output logic [7:0]  spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata,
    input  logic        host_req,
    input  logic        host_rnw,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        cfg_done,
    output logic        busy,
    output logic        error
);

    localparam logic [9:0] c_rom_last   = 10'(ROM_DEPTH - 1);
    localparam logic [7:0] c_poll_limit = 8'(POLL_LIMIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_timer;
    logic [9:0]  r_rom_addr;
    logic [15:0] r_rom_word;
    logic [7:0]  r_poll_cnt;
    logic        r_cfg_done;
    logic        r_error;
    logic        r_host_ack;
    logic [7:0]  r_host_rdata;
    logic        r_host_from_err;

    logic        w_txn_start;
    logic        w_txn_rnw;
    logic [7:0]  w_txn_addr;
    logic [7:0]  w_txn_wdata;
    logic        w_txn_done;
    logic        w_rom_adv;
    logic        w_poll_fail;
    logic        w_lock;
    logic        w_restart;
    logic        w_host_go;
    logic        w_host_fin;
    logic [7:0]  w_poll_inc;

    assign w_poll_inc = r_poll_cnt + 8'd1;

    si53xx_txn_issuer u_issuer (
        .clk      (clk),
        .reset    (reset),
        .start    (w_txn_start),
        .rnw      (w_txn_rnw),
        .addr     (w_txn_addr),
        .wdata    (w_txn_wdata),
        .spi_done (spi_done),
        .spi_req  (spi_req),
        .spi_rnw  (spi_rnw),
        .spi_addr (spi_addr),
        .spi_wdata(spi_wdata),
        .txn_done (w_txn_done)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transaction control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_txn_start  = 1'b0;
        w_txn_rnw    = 1'b0;
        w_txn_addr   = 8'h00;
        w_txn_wdata  = 8'h00;
        w_rom_adv    = 1'b0;
        w_poll_fail  = 1'b0;
        w_lock       = 1'b0;
        w_restart    = 1'b0;
        w_host_go    = 1'b0;
        w_host_fin   = 1'b0;

        case (r_state)
            ST_STARTUP: begin
                if (r_timer == STARTUP_CYCLES - 32'd1) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_ROM_WAIT;
            end
            ST_ROM_WAIT: begin
                w_state_next = (rom_data[15:8] == C_DELAY_MARKER) ? ST_DELAY : ST_ROM_WR;
            end
            ST_ROM_WR: begin
                // Request is raised in the first cycle of the state only;
                // the state is left on the done edge.
                w_txn_start = ~spi_req;
                w_txn_addr  = r_rom_word[15:8];
                w_txn_wdata = r_rom_word[7:0];
                if (w_txn_done) begin
                    w_rom_adv    = 1'b1;
                    w_state_next = (r_rom_addr == c_rom_last) ? ST_POLL_PG : ST_FETCH;
                end
            end
            ST_DELAY: begin
                if (r_timer == DELAY_CYCLES - 32'd1) begin
                    w_rom_adv    = 1'b1;
                    w_state_next = (r_rom_addr == c_rom_last) ? ST_POLL_PG : ST_FETCH;
                end
            end
            ST_POLL_PG: begin
                w_txn_start = ~spi_req;
                w_txn_addr  = C_PAGE_REG;
                w_txn_wdata = C_PAGE0;
                if (w_txn_done) begin
                    w_state_next = ST_POLL_RD;
                end
            end
            ST_POLL_RD: begin
                w_txn_start = ~spi_req;
                w_txn_rnw   = 1'b1;
                w_txn_addr  = STATUS_ADDR;
                if (w_txn_done) begin
                    if ((spi_rdata & STATUS_MASK) == 8'h00) begin
                        w_lock       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_poll_fail  = 1'b1;
                        w_state_next = (w_poll_inc == c_poll_limit) ? ST_ERROR : ST_POLL_WAIT;
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (r_timer == POLL_INTERVAL - 32'd1) begin
                    w_state_next = ST_POLL_RD;
                end
            end
            ST_IDLE, ST_ERROR: begin
                // While host_ack is high the host has not yet had a chance
                // to drop host_req, so that cycle does not start an access.
                if (start_cfg) begin
                    w_restart    = 1'b1;
                    w_state_next = ST_STARTUP;
                end else if (host_req && !r_host_ack) begin
                    w_host_go    = 1'b1;
                    w_txn_start  = 1'b1;
                    w_txn_rnw    = host_rnw;
                    w_txn_addr   = host_addr;
                    w_txn_wdata  = host_wdata;
                    w_state_next = ST_HOST;
                end
            end
            ST_HOST: begin
                if (w_txn_done) begin
                    w_host_fin   = 1'b1;
                    w_state_next = r_host_from_err ? ST_ERROR : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_STARTUP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer         <= 32'd0;
            r_rom_addr      <= 10'd0;
            r_rom_word      <= 16'h0000;
            r_poll_cnt      <= 8'd0;
            r_cfg_done      <= 1'b0;
            r_error         <= 1'b0;
            r_host_ack      <= 1'b0;
            r_host_rdata    <= 8'h00;
            r_host_from_err <= 1'b0;
        end else begin
            // Single timer shared by STARTUP, DELAY and POLL_WAIT: it
            // restarts from zero on every state change.
            r_timer    <= (w_state_next != r_state) ? 32'd0 : r_timer + 32'd1;
            r_host_ack <= w_host_fin;

            if (r_state == ST_ROM_WAIT) begin
                r_rom_word <= rom_data;
            end
            // Address saturates at the last entry
            if (w_rom_adv && (r_rom_addr != c_rom_last)) begin
                r_rom_addr <= r_rom_addr + 10'd1;
            end
            if (w_poll_fail) begin
                r_poll_cnt <= w_poll_inc;
                if (w_poll_inc == c_poll_limit) begin
                    r_error <= 1'b1;
                end
            end
            if (w_lock) begin
                r_cfg_done <= 1'b1;
            end
            if (w_restart) begin
                r_rom_addr <= 10'd0;
                r_poll_cnt <= 8'd0;
                r_cfg_done <= 1'b0;
                r_error    <= 1'b0;
            end
            if (w_host_go) begin
                r_host_from_err <= (r_state == ST_ERROR);
            end
            if (w_host_fin && spi_rnw) begin
                r_host_rdata <= spi_rdata;
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;
    assign cfg_done   = r_cfg_done;
    assign error      = r_error;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_si53xx_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_si53xx_cfg_sequencer
// Description : Self-checking bench for si53xx_cfg_sequencer with a 4-entry
//               ROM, a 3-cycle SPI engine model and a transaction log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_si53xx_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_cfg = 1'b0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        spi_req, spi_rnw;
    logic [7:0]  spi_addr, spi_wdata;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rdata = 8'h00;
    logic        host_req = 1'b0, host_rnw = 1'b0;
    logic [7:0]  host_addr = 8'h00, host_wdata = 8'h00;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        cfg_done, busy, error;

    always #5 clk = ~clk;

    si53xx_cfg_sequencer #(
        .ROM_DEPTH     (4),
        .STARTUP_CYCLES(32'd5),
        .DELAY_CYCLES  (32'd10),
        .POLL_INTERVAL (32'd4),
        .POLL_LIMIT    (3),
        .STATUS_ADDR   (8'h0C),
        .STATUS_MASK   (8'h0F)
    ) dut (
        .clk(clk), .reset(reset), .start_cfg(start_cfg),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .spi_req(spi_req), .spi_rnw(spi_rnw), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .cfg_done(cfg_done), .busy(busy), .error(error)
    );

    // ---------------- ROM model (registered read) ----------------
    logic [15:0] rom_tab [0:3] = '{16'h0B24, 16'hFF00, 16'h0AB1, 16'h0C00};
    always @(posedge clk) rom_data <= rom_tab[rom_addr[1:0]];

    // ---------------- SPI engine model ----------------
    logic [7:0] stat_tab [0:3];
    int         stat_n = 0;
    int         stat_idx = 0;
    logic [7:0] stat_default = 8'h00;
    logic [7:0] other_rd = 8'h00;
    logic       clr = 1'b0;
    logic [1:0] eng_cnt = 2'd0;
    logic [7:0] w_resp;

    assign w_resp = (spi_addr == 8'h0C) ? ((stat_idx < stat_n) ? stat_tab[stat_idx[1:0]] : stat_default)
                                        : other_rd;

    always @(posedge clk) begin
        if (spi_req && !spi_done) begin
            if (eng_cnt == 2'd2) begin
                spi_done  <= 1'b1;
                spi_rdata <= w_resp;
                eng_cnt   <= 2'd0;
            end else begin
                spi_done <= 1'b0;
                eng_cnt  <= eng_cnt + 2'd1;
            end
        end else begin
            spi_done <= 1'b0;
            eng_cnt  <= 2'd0;
        end
    end

    // ---------------- Transaction log and counters ----------------
    logic       log_rnw   [0:31];
    logic [7:0] log_addr  [0:31];
    logic [7:0] log_wdata [0:31];
    int         log_cyc   [0:31];
    int         log_n = 0;
    int         ack_cnt = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            log_n    <= 0;
            stat_idx <= 0;
        end else if (spi_req && spi_done) begin
            if (log_n < 32) begin
                log_rnw[log_n]   <= spi_rnw;
                log_addr[log_n]  <= spi_addr;
                log_wdata[log_n] <= spi_wdata;
                log_cyc[log_n]   <= cyc;
                log_n            <= log_n + 1;
            end
            if (spi_rnw && spi_addr == 8'h0C && stat_idx < stat_n) stat_idx <= stat_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (clr) ack_cnt <= 0;
        else if (host_ack) ack_cnt <= ack_cnt + 1;
    end

    // ---------------- Checking helpers ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // sel: 0 cfg_done, 1 error, 2 host_ack, 3 request with rom_addr==2
    task automatic wait_cond(input int sel, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = cfg_done;
                1:       hit = error;
                2:       hit = host_ack;
                default: hit = spi_req && (rom_addr == 10'd2);
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    function automatic int status_reads();
        int n = 0;
        for (int i = 0; i < log_n; i++) if (log_rnw[i] && log_addr[i] == 8'h0C) n++;
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start_cfg = 1'b1;
        @(posedge clk);
        #1 start_cfg = 1'b0;
    endtask

    typedef struct {
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct {
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] eng_rd;
        logic [7:0] exp_rdata;
    } hvec_t;

    task automatic host_access(input hvec_t v, input string name);
        @(negedge clk);
        other_rd = v.eng_rd;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        host_rnw = v.rnw; host_addr = v.addr; host_wdata = v.wdata; host_req = 1'b1;
        wait_cond(2, 50, {name, " ack"});
        @(posedge clk);
        #1 host_req = 1'b0;
        repeat (6) @(negedge clk);
        chk({name, " ack count"}, ack_cnt, 1);
        chk({name, " txn count"}, log_n, 1);
        chk({name, " spi_rnw"}, log_rnw[0], v.rnw);
        chk({name, " spi_addr"}, log_addr[0], v.addr);
        if (!v.rnw) chk({name, " spi_wdata"}, log_wdata[0], v.wdata);
        chk({name, " host_rdata"}, host_rdata, v.exp_rdata);
    endtask

    txn_t  exp_bring [0:7];
    hvec_t host_tab  [0:2];
    hvec_t err_vec;

    initial begin
        exp_bring[0] = '{1'b0, 8'h0B, 8'h24};
        exp_bring[1] = '{1'b0, 8'h0A, 8'hB1};
        exp_bring[2] = '{1'b0, 8'h0C, 8'h00};
        exp_bring[3] = '{1'b0, 8'h01, 8'h00};
        exp_bring[4] = '{1'b1, 8'h0C, 8'h00};
        exp_bring[5] = '{1'b1, 8'h0C, 8'h00};
        exp_bring[6] = '{1'b1, 8'h0C, 8'h00};
        exp_bring[7] = '{1'b1, 8'h0E, 8'h00};
        // Write leaves host_rdata at the previous read result
        host_tab[0] = '{1'b1, 8'h0E, 8'h00, 8'hA5, 8'hA5};
        host_tab[1] = '{1'b0, 8'h20, 8'h33, 8'h99, 8'hA5};
        host_tab[2] = '{1'b1, 8'h10, 8'h00, 8'h3C, 8'h3C};
        err_vec     = '{1'b1, 8'h0E, 8'h00, 8'h77, 8'h77};

        stat_tab[0] = 8'h08; stat_tab[1] = 8'h08; stat_tab[2] = 8'h00; stat_tab[3] = 8'h00;
        stat_n = 3;
        other_rd = 8'h5A;
        // Host read held from reset: stalled until bring-up completes
        host_rnw = 1'b1; host_addr = 8'h0E; host_req = 1'b1;

        // ---- reset state ----
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("reset rom_addr", rom_addr, 0);
        chk("reset spi_req", spi_req, 0);
        chk("reset host_ack", host_ack, 0);
        chk("reset host_rdata", host_rdata, 0);
        chk("reset cfg_done", cfg_done, 0);
        chk("reset error", error, 0);
        chk("reset busy", busy, 1);
        reset = 1'b0;

        // ---- bring-up with two failing status reads ----
        wait_cond(0, 1000, "bringup cfg_done");
        chk("lock txn count", log_n, 7);
        chk("lock status reads", status_reads(), 3);
        chk("cfg_done edge after 3rd read", cyc - log_cyc[6], 1);
        chk("lock error", error, 0);
        chk("lock busy", busy, 0);
        chk("no ack during bringup", ack_cnt, 0);
        wait_cond(2, 50, "stalled host ack");
        @(posedge clk);
        #1 host_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("stalled host ack count", ack_cnt, 1);
        chk("stalled host rdata", host_rdata, 8'h5A);
        chk("bringup txn count", log_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bringup txn%0d rnw", i), log_rnw[i], exp_bring[i].rnw);
            chk($sformatf("bringup txn%0d addr", i), log_addr[i], exp_bring[i].addr);
            if (!exp_bring[i].rnw) chk($sformatf("bringup txn%0d wdata", i), log_wdata[i], exp_bring[i].wdata);
        end
        chk("delay gap >= 10", (log_cyc[1] - log_cyc[0]) >= 10, 1);

        // ---- host accesses in IDLE ----
        for (int i = 0; i < 3; i++) host_access(host_tab[i], $sformatf("host%0d", i));

        // ---- start_cfg and host_req together in IDLE ----
        @(negedge clk);
        clr = 1'b1;
        stat_tab[0] = 8'h00;
        stat_n = 1;
        @(negedge clk);
        clr = 1'b0;
        other_rd = 8'hC3;
        host_rnw = 1'b1; host_addr = 8'h0E; host_req = 1'b1; start_cfg = 1'b1;
        @(posedge clk);
        #1 start_cfg = 1'b0;
        @(negedge clk);
        chk("prio busy", busy, 1);
        chk("prio cfg_done cleared", cfg_done, 0);
        chk("prio no host req", spi_req, 0);
        chk("prio rom_addr", rom_addr, 0);
        wait_cond(0, 1000, "prio cfg_done");
        wait_cond(2, 50, "prio host ack");
        @(posedge clk);
        #1 host_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("prio txn count", log_n, 6);
        chk("prio first addr", log_addr[0], 8'h0B);
        chk("prio last rnw", log_rnw[5], 1);
        chk("prio last addr", log_addr[5], 8'h0E);
        chk("prio host_rdata", host_rdata, 8'hC3);
        chk("prio ack count", ack_cnt, 1);

        // ---- poll exhaustion -> ERROR ----
        @(negedge clk);
        clr = 1'b1;
        stat_n = 0;
        stat_default = 8'h01;
        @(negedge clk);
        clr = 1'b0;
        pulse_start();
        wait_cond(1, 1000, "poll error");
        chk("err status reads", status_reads(), 3);
        chk("err error", error, 1);
        chk("err busy", busy, 0);
        chk("err cfg_done", cfg_done, 0);
        host_access(err_vec, "errhost");
        chk("errhost error held", error, 1);
        chk("errhost busy", busy, 0);
        stat_default = 8'h00;
        pulse_start();
        @(negedge clk);
        chk("retry error cleared", error, 0);
        chk("retry rom_addr", rom_addr, 0);
        chk("retry busy", busy, 1);
        wait_cond(0, 1000, "retry cfg_done");
        chk("retry error", error, 0);

        // ---- reset during a ROM write ----
        pulse_start();
        wait_cond(3, 1000, "rom write 2 req");
        reset = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("abort spi_req", spi_req, 0);
        chk("abort rom_addr", rom_addr, 0);
        chk("abort busy", busy, 1);
        reset = 1'b0;
        clr = 1'b0;
        wait_cond(0, 1000, "rerun cfg_done");
        chk("rerun txn count", log_n, 5);
        chk("rerun txn0 addr", log_addr[0], 8'h0B);
        chk("rerun txn0 wdata", log_wdata[0], 8'h24);
        chk("rerun txn1 addr", log_addr[1], 8'h0A);
        chk("rerun txn4 rnw", log_rnw[4], 1);
        chk("rerun txn4 addr", log_addr[4], 8'h0C);
        chk("rerun error", error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
